// File: rtl/instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_pkg
// Shared definitions for the ARMv4 fetch front end: instruction width, fetch
// FSM state encoding, the default reset PC, and the queue-entry record that
// also travels on the decode-stage ports.
// -----------------------------------------------------------------------------
package instr_fetch_queue_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM states. The enum documents the encoding; the FSM itself uses
    // the plain logic constants below so older tools can consume the package.
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [1:0] ST_FETCH = 2'(FS_FETCH);
    localparam logic [1:0] ST_WAIT  = 2'(FS_WAIT);
    localparam logic [1:0] ST_FLUSH = 2'(FS_FLUSH);

    // One prefetch-queue slot: the fetch address and the word read from it.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_if
// Bundles the fetch stage's external channels:
//   - instruction-memory request (valid/ready) and response (valid only)
//   - redirect input from branch/exception resolution
//   - instruction register handed to decode (valid/ready)
// master: the fetch stage.  slave: memory, redirect source and decode.
// -----------------------------------------------------------------------------
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [31:0]        mem_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               redir_valid;
    logic [31:0]        redir_addr;
    logic [INSTR_W-1:0] ir;
    logic [31:0]        ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output mem_req_valid, mem_addr, ir, ir_pc, ir_valid,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redir_valid, redir_addr, ir_ready
    );

    modport slave (
        input  mem_req_valid, mem_addr, ir, ir_pc, ir_valid,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redir_valid, redir_addr, ir_ready
    );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_fetch_fifo
// DEPTH-entry synchronous circular FIFO of fetch entries.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   flush     - clears pointers and count; overrides same-cycle push/pop
//   wr_en     - push wr_data (must not be asserted while full)
//   rd_en     - pop the head entry (ignored when empty)
//   rd_data   - head entry, read combinationally
//   count     - number of valid entries, 0..DEPTH
// Storage is not cleared by flush, so an empty FIFO still shows the last
// contents of the head slot; consumers qualify with count.
// -----------------------------------------------------------------------------
module instr_fetch_queue_fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  fetch_entry_t                 wr_data,
    input  logic                         rd_en,
    output fetch_entry_t                 rd_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire;
    logic             rd_fire;

    fetch_entry_t entry_view [DEPTH];

    // Flush wins over any same-cycle push or pop.
    assign wr_fire = wr_en && !flush;
    assign rd_fire = rd_en && !flush && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_fire);
            count_d  = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (wr_fire && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_q <= wr_data;
                end
            end

            assign entry_view[gi] = entry_q;
        end
    endgenerate

    assign rd_data = entry_view[rd_ptr_q];
    assign count   = count_q;

`ifndef SYNTHESIS
    // The issue condition upstream reserves a slot for every outstanding
    // request, so a push into a full FIFO indicates broken credit logic.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            assert (count_q != DEPTH_L)
                else $error("fetch_fifo: enqueue while full");
        end
    end
`endif

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage of the ARMv4 front end. Owns the fetch PC, issues one word read
// at a time to instruction memory, buffers returned words with their fetch
// addresses in a DEPTH-entry prefetch queue and presents the head entry to
// decode as ir / ir_pc / ir_valid.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - master side of instr_fetch_queue_if:
//               mem_req_valid/mem_req_ready/mem_addr  request channel
//               mem_rsp_valid/mem_rsp_data            response channel
//               redir_valid/redir_addr                redirect/flush
//               ir/ir_pc/ir_valid/ir_ready            decode handoff
// Parameters:
//   DEPTH     - prefetch queue entries, power of two, 2..8
//   RESET_PC  - first fetch address after reset, word aligned
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_queue_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      issued_q, issued_d;
    logic             outstanding_q, outstanding_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    fetch_entry_t     head;
    fetch_entry_t     enq_entry;
    logic             enq;
    logic             deq;
    logic             req_valid;
    logic             accept;
    logic             ir_valid;
    logic [31:0]      redir_pc;
    logic             unused_redir_lsb;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign redir_pc         = {bus.redir_addr[31:2], 2'b00};
    assign unused_redir_lsb = ^bus.redir_addr[1:0];

    // Issue only if the returning word is guaranteed a free slot, counting
    // the request already in flight.
    assign inflight  = {1'b0, fifo_count} + (CNT_W + 1)'(outstanding_q);
    assign req_valid = !rst && (state_q == ST_FETCH) && (inflight < DEPTH_L);
    assign accept    = req_valid && bus.mem_req_ready;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_addr      = pc_q;

    assign ir_valid     = (fifo_count != '0);
    assign bus.ir_valid = ir_valid;
    assign bus.ir       = head.instr;
    assign bus.ir_pc    = head.pc;
    assign deq          = ir_valid && bus.ir_ready;

    // The entry's address is the one latched when the request was accepted,
    // not the (already advanced) fetch PC.
    assign enq_entry = '{pc: issued_q, instr: bus.mem_rsp_data};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        enq           = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    issued_d      = pc_q;
                    pc_d          = next_pc(pc_q);
                    outstanding_d = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    enq           = 1'b1;
                    outstanding_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                // Response belongs to a request issued before a redirect.
                if (bus.mem_rsp_valid) begin
                    outstanding_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                outstanding_d = 1'b0;
                state_d       = ST_FETCH;
            end
        endcase

        // Redirect overrides everything above. Whether a response is still
        // owed (outstanding_d already folds in a same-cycle acceptance or a
        // same-cycle response) decides between draining it and fetching.
        if (bus.redir_valid) begin
            pc_d    = redir_pc;
            enq     = 1'b0;
            state_d = outstanding_d ? ST_FLUSH : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            issued_q      <= RESET_PC;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
        end
    end

    instr_fetch_queue_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.redir_valid),
        .wr_en   (enq),
        .wr_data (enq_entry),
        .rd_en   (deq),
        .rd_data (head),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed stimulus with scoreboarded checking: stimulus pushes expected
// request addresses and expected decode-side fetch addresses into queues;
// negedge monitors pop and compare whenever the DUT presents a transfer.
// A second instance with RESET_PC=0xFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();
    instr_fetch_queue_if wbus ();

    instr_fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_fetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] req_exp  [$];
    logic [31:0] irpc_exp [$];
    logic [31:0] wrap_exp [$];

    // Memory contents: a fixed scramble of the address, never equal to it.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_5A00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %-16s got %08h", name, act);
        end else begin
            $display("FAIL %-16s got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main memory model: fixed latency, one pending ----------
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_pend_addr;
    bit          seen_addr4 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mem_cnt           = 0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end else begin
            bus.mem_rsp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(mem_pend_addr);
                end
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                mem_cnt       = mem_lat;
                mem_pend_addr = bus.mem_addr;
            end
        end
    end

    // ---------------- request monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
            if (bus.mem_addr == 32'h4) seen_addr4 = 1'b1;
            if (req_exp.size() > 0) check("req_addr", bus.mem_addr, req_exp.pop_front());
        end
    end

    // ---------------- decode-side monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && bus.ir_valid && bus.ir_ready && irpc_exp.size() > 0) begin
            e = irpc_exp.pop_front();
            check("ir_pc", bus.ir_pc, e);
            check("ir", bus.ir, mem_word(e));
        end
    end

    // ---------------- wrap instance: 1-cycle memory and monitor ----------------
    bit          w_pend = 1'b0;
    logic [31:0] w_pend_addr = '0;

    always @(negedge clk) begin
        logic [31:0] e;
        wbus.mem_rsp_valid = w_pend && !rst;
        wbus.mem_rsp_data  = mem_word(w_pend_addr);
        w_pend      = !rst && wbus.mem_req_valid && wbus.mem_req_ready;
        w_pend_addr = wbus.mem_addr;
        if (!rst && wbus.ir_valid && wbus.ir_ready && wrap_exp.size() > 0) begin
            e = wrap_exp.pop_front();
            check("wrap_ir_pc", wbus.ir_pc, e);
            check("wrap_ir", wbus.ir, mem_word(e));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.redir_valid = 1'b0;
        req_exp.delete();
        irpc_exp.delete();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic expect_drained(input string name);
        check({name, "_req_left"}, 32'(req_exp.size()), 32'd0);
        check({name, "_ir_left"}, 32'(irpc_exp.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.redir_valid    = 1'b0;
        bus.redir_addr     = '0;
        bus.ir_ready       = 1'b1;
        wbus.mem_req_ready = 1'b1;
        wbus.redir_valid   = 1'b0;
        wbus.redir_addr    = '0;
        wbus.ir_ready      = 1'b1;
        wrap_exp.push_back(32'hFFFF_FFFC);
        wrap_exp.push_back(32'h0000_0000);

        // ---- Test 1: reset state, then in-order stream 0x0, 0x4, 0x8 ----
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_ir", bus.ir, 32'h0);
        check("rst_ir_pc", bus.ir_pc, 32'h0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        rst = 1'b0;
        mem_lat = 1;
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        req_exp.push_back(32'h8);
        irpc_exp.push_back(32'h0);
        irpc_exp.push_back(32'h4);
        irpc_exp.push_back(32'h8);
        @(negedge clk);
        check("t1_first_valid", 32'(bus.mem_req_valid), 32'd1);
        repeat (12) tick();
        expect_drained("t1");

        // ---- Test 2: backpressure with DEPTH=2 ----
        bus.ir_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_req_blocked", 32'(bus.mem_req_valid), 32'd0);
            tick();
        end
        check("t2_ir_valid", 32'(bus.ir_valid), 32'd1);
        irpc_exp.push_back(32'h0);
        req_exp.push_back(32'h8);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        repeat (5) tick();
        check("t2_req_left", 32'(req_exp.size()), 32'd0);
        irpc_exp.push_back(32'h4);
        irpc_exp.push_back(32'h8);
        bus.ir_ready = 1'b1;
        repeat (8) tick();
        expect_drained("t2");

        // ---- Test 3: stall on grant ----
        bus.mem_req_ready = 1'b0;
        bus.ir_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_valid", 32'(bus.mem_req_valid), 32'd1);
            check("t3_stall_addr", bus.mem_addr, 32'h0);
            tick();
        end
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        irpc_exp.push_back(32'h0);
        irpc_exp.push_back(32'h4);
        bus.mem_req_ready = 1'b1;
        repeat (8) tick();
        expect_drained("t3");

        // ---- Test 4: redirect with response in flight ----
        mem_lat = 3;
        bus.ir_ready = 1'b1;
        do_reset();
        seen_addr4 = 1'b0;
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        irpc_exp.push_back(32'h0);
        for (int i = 0; i < 30 && !seen_addr4; i++) tick();
        check("t4_saw_req4", 32'(seen_addr4), 32'd1);
        bus.redir_valid = 1'b1;
        bus.redir_addr  = 32'h0000_1003;
        tick();
        bus.redir_valid = 1'b0;
        req_exp.push_back(32'h1000);
        req_exp.push_back(32'h1004);
        irpc_exp.push_back(32'h1000);
        irpc_exp.push_back(32'h1004);
        @(negedge clk);
        check("t4_flush_noreq", 32'(bus.mem_req_valid), 32'd0);
        check("t4_ir_valid", 32'(bus.ir_valid), 32'd0);
        repeat (20) tick();
        expect_drained("t4");

        // ---- Test 5: redirect with full queue and same-cycle dequeue ----
        mem_lat = 1;
        bus.ir_ready = 1'b0;
        do_reset();
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        repeat (10) tick();
        irpc_exp.push_back(32'h0);
        bus.ir_ready    = 1'b1;
        bus.redir_valid = 1'b1;
        bus.redir_addr  = 32'h0000_2000;
        tick();
        bus.ir_ready    = 1'b0;
        bus.redir_valid = 1'b0;
        req_exp.push_back(32'h2000);
        req_exp.push_back(32'h2004);
        @(negedge clk);
        check("t5_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("t5_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("t5_mem_addr", bus.mem_addr, 32'h2000);
        irpc_exp.push_back(32'h2000);
        irpc_exp.push_back(32'h2004);
        tick();
        bus.ir_ready = 1'b1;
        repeat (12) tick();
        expect_drained("t5");

        // ---- Wrap instance ran alongside from the first reset ----
        check("wrap_left", 32'(wrap_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
